fifo_uart_tx: RTL and testbench

Serial transmitter that drains bytes from the 16x8 FIFO and sends each one on a single line as an 8N1 UART frame. It sits directly downstream of the FIFO. It drives the FIFO read enable, captures the registered FIFO read data one cycle later, and serializes it LSB first at a rate set by a parameter. It gives the producer side a busy flag and a per-byte completion pulse.

---
 rtl/fifo_uart_pkg.sv | 22 ++
 rtl/fifo_uart_tx_if.sv | 34 +++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/fifo_uart_tx.sv | 108 ++++++++++
 tb/tb_fifo_uart_tx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed 8N1 UART transmitter.
// One frame is a start bit, eight data bits and a stop bit.
package fifo_uart_pkg;

    localparam int unsigned DATA_W               = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
    localparam int unsigned UART_FRAME_BITS      = 10;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Clock cycles from the falling edge of the start bit to the byte_done cycle, inclusive.
    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit);
        return UART_FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read side plus serial line and status signals of the UART transmitter.
// The master modport is the transmitter; the slave modport is the FIFO/producer side.
interface fifo_uart_tx_if;
    import fifo_uart_pkg::*;

    logic              tx_en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_re;
    logic              tx;
    logic              busy;
    logic              byte_done;

    modport master (
        input  tx_en,
        input  fifo_empty,
        input  fifo_data,
        output fifo_re,
        output tx,
        output busy,
        output byte_done
    );

    modport slave (
        output tx_en,
        output fifo_empty,
        output fifo_data,
        input  fifo_re,
        input  tx,
        input  busy,
        input  byte_done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// The counter wraps on its own, so consecutive bits need no reload.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the upstream FIFO and sends each as an 8N1 frame, LSB first.
// fifo_re is the only output that depends combinationally on inputs.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = fifo_uart_pkg::CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_W       = fifo_uart_pkg::DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus
);

    import fifo_uart_pkg::*;

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              fifo_re;
    logic              byte_done;
    logic              timer_clear;
    logic              tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        fifo_re     = 1'b0;
        byte_done   = 1'b0;
        timer_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_clear = 1'b1;
                tx_d        = 1'b1;
                // Gating on ~fifo_empty guarantees we never pop an empty FIFO.
                fifo_re     = bus.tx_en & ~bus.fifo_empty & ~rst;
                if (fifo_re) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Pop already committed; read data is valid now regardless of fifo_empty.
                shift_d     = bus.fifo_data;
                tx_d        = 1'b0;
                timer_clear = 1'b1;
                state_d     = StStart;
            end
            StStart: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    byte_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    assign bus.fifo_re   = fifo_re;
    assign bus.tx        = tx_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.byte_done = byte_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, UART line decoder and byte scoreboard.
module tb_fifo_uart_tx;

    localparam int unsigned C = 4;

    logic clk = 1'b0;
    logic rst;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(
        .CLKS_PER_BIT(C),
        .DATA_W      (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model: write side owned by the stimulus, read side by the clocked pop.
    logic [7:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_re === 1'b1 && wr_ptr != rd_ptr) begin
            bus.fifo_data <= mem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
        end
    end

    logic [7:0] exp_q[$];

    task automatic push_byte(input logic [7:0] b, input bit will_send);
        mem[wr_ptr % 256] = b;
        wr_ptr = wr_ptr + 1;
        if (will_send) exp_q.push_back(b);
    endtask

    // Line decoder and event counters, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int re_count = 0;
    int done_count = 0;
    int tx_low_count = 0;
    int re_empty_viol = 0;
    int frames_seen = 0;
    int falls[$];
    bit mon_active = 0;
    int mon_off = 0;
    bit mon_ok = 1;
    logic mon_level;
    logic [7:0] mon_byte;
    logic [9:0] mon_bits;
    logic [9:0] last_bits;

    always @(negedge clk) begin
        if (bus.fifo_re === 1'b1) re_count++;
        if (bus.fifo_re === 1'b1 && bus.fifo_empty) re_empty_viol++;
        if (bus.byte_done === 1'b1) done_count++;
        if (bus.tx === 1'b0) tx_low_count++;
        if (rst !== 1'b0) begin
            mon_active = 0;
        end else begin
            if (mon_active) begin
                mon_off++;
            end else if (bus.tx === 1'b0) begin
                mon_active = 1;
                mon_off = 0;
                mon_ok = 1;
                falls.push_back(cyc);
            end
            if (mon_active) begin
                int slot;
                int pos;
                slot = mon_off / C;
                pos = mon_off % C;
                if (pos == 0) begin
                    mon_level = bus.tx;
                    mon_bits[slot] = bus.tx;
                    if (slot >= 1 && slot <= 8) mon_byte[slot-1] = bus.tx;
                    if (slot == 0 && bus.tx !== 1'b0) mon_ok = 0;
                    if (slot == 9 && bus.tx !== 1'b1) mon_ok = 0;
                end else if (bus.tx !== mon_level) begin
                    mon_ok = 0;
                end
                if (mon_off == int'(fifo_uart_pkg::frame_cycles(C)) - 1) begin
                    check("frame_shape", 32'(mon_ok), 32'd1);
                    check("byte_done_end_of_stop", 32'(bus.byte_done), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(mon_byte), 32'hFFFF_FFFF);
                    end else begin
                        check("frame_data", 32'(mon_byte), 32'(exp_q.pop_front()));
                    end
                    last_bits = mon_bits;
                    frames_seen++;
                    mon_active = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int tgt;
        tgt = frames_seen + n;
        for (int i = 0; i < budget && frames_seen < tgt; i++) step(1);
        check("frames_done", 32'(frames_seen), 32'(tgt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int re0;
        int done0;
        int low0;
        int fb;
        int seq_a5[10];
        logic [9:0] exp_bits;

        rst = 1'b0;
        bus.tx_en = 1'b0;

        // 1. Asynchronous reset between clock edges.
        #3 rst = 1'b1;
        #1;
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_fifo_re", 32'(bus.fifo_re), 32'd0);
        check("rst_byte_done", 32'(bus.byte_done), 32'd0);
        step(3);
        rst = 1'b0;
        step(2);

        // 2. Single byte 0xA5.
        seq_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        for (int i = 0; i < 10; i++) exp_bits[i] = seq_a5[i][0];
        re0 = re_count;
        done0 = done_count;
        push_byte(8'hA5, 1);
        bus.tx_en = 1'b1;
        wait_frames(1, 200);
        step(10);
        check("a5_bit_sequence", 32'(last_bits), 32'(exp_bits));
        check("a5_pops", 32'(re_count - re0), 32'd1);
        check("a5_byte_done_count", 32'(done_count - done0), 32'd1);

        // 3. Back-to-back frames.
        re0 = re_count;
        fb = falls.size();
        push_byte(8'h00, 1);
        push_byte(8'hFF, 1);
        push_byte(8'h3C, 1);
        wait_frames(3, 500);
        step(10);
        check("b2b_pops", 32'(re_count - re0), 32'd3);
        if (falls.size() >= fb + 3) begin
            for (int k = 0; k < 2; k++)
                check("b2b_high_gap", 32'(falls[fb+k+1] - falls[fb+k] - 9 * C), 32'd6);
        end else begin
            check("b2b_fall_count", 32'(falls.size() - fb), 32'd3);
        end

        // 4. Gating: empty FIFO, tx_en low, tx_en dropped mid-frame.
        re0 = re_count;
        low0 = tx_low_count;
        step(30);
        check("empty_no_pop", 32'(re_count - re0), 32'd0);
        check("empty_tx_high", 32'(tx_low_count - low0), 32'd0);
        bus.tx_en = 1'b0;
        push_byte(8'h11, 1);
        push_byte(8'h22, 0);
        step(30);
        check("disabled_no_pop", 32'(re_count - re0), 32'd0);
        check("disabled_tx_high", 32'(tx_low_count - low0), 32'd0);
        bus.tx_en = 1'b1;
        step(1);
        check("enabled_busy", 32'(bus.busy), 32'd1);
        bus.tx_en = 1'b0;
        wait_frames(1, 200);
        step(30);
        check("drop_en_pops", 32'(re_count - re0), 32'd1);
        check("drop_en_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
        wr_ptr = rd_ptr;

        // 5. Reset during data bit 3 of 0x5A.
        fb = falls.size();
        bus.tx_en = 1'b1;
        push_byte(8'h5A, 0);
        for (int i = 0; i < 50 && falls.size() == fb; i++) step(1);
        check("rst5_frame_started", 32'(falls.size() - fb), 32'd1);
        step(4 * C + 1);
        check("rst5_busy_before", 32'(bus.busy), 32'd1);
        #2;
        done0 = done_count;
        rst = 1'b1;
        #1;
        check("rst5_tx_high", 32'(bus.tx), 32'd1);
        check("rst5_busy_low", 32'(bus.busy), 32'd0);
        check("rst5_fifo_re_low", 32'(bus.fifo_re), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        check("rst5_no_done", 32'(done_count - done0), 32'd0);
        push_byte(8'h81, 1);
        wait_frames(1, 200);
        step(5);
        check("rst5_next_done", 32'(done_count - done0), 32'd1);

        // 6. Single byte then empty.
        re0 = re_count;
        push_byte(8'h7E, 1);
        wait_frames(1, 200);
        step(40);
        check("last_byte_pops", 32'(re_count - re0), 32'd1);
        check("re_while_empty", 32'(re_empty_viol), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("done_vs_frames", 32'(done_count), 32'(frames_seen));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
